// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache: FSM states,
// default geometry and the address-field width helpers.
package cache_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LINE_WORDS = 8;
    localparam int DEF_NUM_LINES  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } cache_state_e;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Bit 0 of the byte address is never part of the tag.
    function automatic int tag_w(input int addr_w, input int line_words, input int num_lines);
        return addr_w - 1 - offset_w(line_words) - index_w(num_lines);
    endfunction

endpackage

// File: rtl/dm_cache_if.sv
// CPU-side and memory-side bus bundles of the cache; the cache is the slave
// of the CPU bus and the master of the memory bus.
interface cpu_bus_if #(
    parameter int ADDR_W = cache_pkg::DEF_ADDR_W,
    parameter int DATA_W = cache_pkg::DEF_DATA_W
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;

    modport master (output req_valid, req_wr, req_addr, req_wdata, input rdata, stall);
    modport slave  (input req_valid, req_wr, req_addr, req_wdata, output rdata, stall);
endinterface

interface mem_bus_if #(
    parameter int ADDR_W = cache_pkg::DEF_ADDR_W,
    parameter int DATA_W = cache_pkg::DEF_DATA_W
);
    logic              mem_req_valid;
    logic              mem_req_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req_valid, mem_req_wr, mem_addr, mem_wdata,
                    input mem_ready, mem_rvalid, mem_rdata);
    modport slave  (input mem_req_valid, mem_req_wr, mem_addr, mem_wdata,
                    output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/cache_data_array.sv
// Cache data storage: one word-granular asynchronous read port for
// zero-latency hits and one synchronous write port shared by fill and store.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    localparam int WORD_AW   = index_w(NUM_LINES) + offset_w(LINE_WORDS)
) (
    input  logic               clk,
    input  logic [WORD_AW-1:0] raddr,
    output logic [DATA_W-1:0]  rdata,
    input  logic               we,
    input  logic [WORD_AW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata
);

    logic [DATA_W-1:0] mem_q [NUM_LINES*LINE_WORDS];

    // Word write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with a streaming
// line fill; tag/valid storage, fill counters and the control FSM live here.
module dm_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic     clk,
    input  logic     rst_n,
    cpu_bus_if.slave cpu,
    mem_bus_if.master mem
);

    localparam int OFF_W   = offset_w(LINE_WORDS);
    localparam int IDX_W   = index_w(NUM_LINES);
    localparam int TAG_W   = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
    localparam int WORD_AW = IDX_W + OFF_W;

    localparam logic [OFF_W:0]    REQ_ZERO   = {(OFF_W+1){1'b0}};
    localparam logic [OFF_W:0]    REQ_ONE    = {{OFF_W{1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0]  RSP_ZERO   = {OFF_W{1'b0}};
    localparam logic [OFF_W-1:0]  RSP_ONE    = {{(OFF_W-1){1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0]  LAST_WORD  = {OFF_W{1'b1}};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

    cache_state_e          state_q, state_d;
    logic [OFF_W:0]        req_cnt_q, req_cnt_d;
    logic [OFF_W-1:0]      rsp_cnt_q, rsp_cnt_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_mem_q [NUM_LINES];

    logic [TAG_W-1:0]      req_tag_s;
    logic [IDX_W-1:0]      req_idx_s;
    logic [OFF_W-1:0]      req_off_s;
    logic                  hit_s;
    logic [ADDR_W-1:0]     fill_addr_s;

    logic                  stall_s;
    logic                  mem_valid_s;
    logic                  mem_wr_s;
    logic [ADDR_W-1:0]     mem_addr_s;
    logic                  tag_we_s;
    logic                  arr_we_s;
    logic [WORD_AW-1:0]    arr_waddr_s;
    logic [DATA_W-1:0]     arr_wdata_s;
    logic [DATA_W-1:0]     arr_rdata_s;

    assign req_off_s   = cpu.req_addr[OFF_W:1];
    assign req_idx_s   = cpu.req_addr[OFF_W+IDX_W:OFF_W+1];
    assign req_tag_s   = cpu.req_addr[ADDR_W-1:OFF_W+IDX_W+1];
    assign hit_s       = valid_q[req_idx_s] && (tag_mem_q[req_idx_s] == req_tag_s);
    assign fill_addr_s = {req_tag_s, req_idx_s, req_cnt_q[OFF_W-1:0], 1'b0};

    // Next-state, counter, valid-bit and bus control decode.
    always_comb begin
        state_d     = state_q;
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        valid_d     = valid_q;
        stall_s     = 1'b0;
        mem_valid_s = 1'b0;
        mem_wr_s    = 1'b0;
        mem_addr_s  = fill_addr_s;
        tag_we_s    = 1'b0;
        arr_we_s    = 1'b0;
        arr_waddr_s = {req_idx_s, req_off_s};
        arr_wdata_s = cpu.req_wdata;

        case (state_q)
            ST_IDLE: begin
                if (cpu.req_valid && cpu.req_wr) begin
                    stall_s = 1'b1;
                    state_d = ST_WRITE;
                end else if (cpu.req_valid && !hit_s) begin
                    stall_s   = 1'b1;
                    state_d   = ST_FILL;
                    req_cnt_d = REQ_ZERO;
                    rsp_cnt_d = RSP_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FILL: begin
                stall_s     = 1'b1;
                mem_valid_s = !req_cnt_q[OFF_W];
                if (mem_valid_s && mem.mem_ready) begin
                    req_cnt_d = req_cnt_q + REQ_ONE;
                end else begin
                    req_cnt_d = req_cnt_q;
                end
                // The line goes invalid on the first word so a partial fill never hits.
                if (mem.mem_rvalid) begin
                    arr_we_s    = 1'b1;
                    arr_waddr_s = {req_idx_s, rsp_cnt_q};
                    arr_wdata_s = mem.mem_rdata;
                    if (rsp_cnt_q == LAST_WORD) begin
                        valid_d[req_idx_s] = 1'b1;
                        tag_we_s           = 1'b1;
                        rsp_cnt_d          = RSP_ZERO;
                        req_cnt_d          = REQ_ZERO;
                        state_d            = ST_IDLE;
                    end else begin
                        valid_d[req_idx_s] = (rsp_cnt_q == RSP_ZERO) ? 1'b0 : valid_q[req_idx_s];
                        rsp_cnt_d          = rsp_cnt_q + RSP_ONE;
                    end
                end else begin
                    rsp_cnt_d = rsp_cnt_q;
                end
            end

            ST_WRITE: begin
                stall_s     = !mem.mem_ready;
                mem_valid_s = 1'b1;
                mem_wr_s    = 1'b1;
                mem_addr_s  = cpu.req_addr & ALIGN_MASK;
                if (mem.mem_ready) begin
                    arr_we_s = hit_s;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state with asynchronous reset; an abort leaves every line invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_cnt_q <= REQ_ZERO;
            rsp_cnt_q <= RSP_ZERO;
            valid_q   <= {NUM_LINES{1'b0}};
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            valid_q   <= valid_d;
        end
    end

    // Tag storage is unreset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (tag_we_s) begin
            tag_mem_q[req_idx_s] <= req_tag_s;
        end
    end

    cache_data_array #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_data (
        .clk   (clk),
        .raddr ({req_idx_s, req_off_s}),
        .rdata (arr_rdata_s),
        .we    (arr_we_s),
        .waddr (arr_waddr_s),
        .wdata (arr_wdata_s)
    );

    assign cpu.rdata         = arr_rdata_s;
    assign cpu.stall         = stall_s;
    assign mem.mem_req_valid = mem_valid_s;
    assign mem.mem_req_wr    = mem_wr_s;
    assign mem.mem_addr      = mem_addr_s;
    assign mem.mem_wdata     = cpu.req_wdata;

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed vector table, hand-written
// stall/reset/toggle sequences and random traffic against a memory model.
module tb_dm_cache;
    import cache_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;
    localparam int MISS_STALL = 8 + LAT + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
    mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    dm_cache #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(8), .NUM_LINES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu_if),
        .mem   (mem_if)
    );

    // ---------------- memory responder (latency LAT, in-order) ----------------
    logic ready_force = 1'b1;
    logic tog_en      = 1'b0;
    logic tog_q       = 1'b0;
    bit [15:0] mem_arr  [32768];
    bit        mem_flag [32768];
    logic [2:0]  pv = 3'b000;
    logic [15:0] pd [3];
    int rd_total = 0, wr_total = 0, rsp_total = 0;
    logic [15:0] rd_hist [64];
    logic [15:0] wr_addr_hist [64];
    logic [15:0] wr_data_hist [64];
    logic acc_s;

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return {a[15:1], 1'b0} ^ 16'h1234;
    endfunction

    assign mem_if.mem_ready  = tog_en ? tog_q : ready_force;
    assign mem_if.mem_rvalid = pv[2];
    assign mem_if.mem_rdata  = pd[2];
    assign acc_s = mem_if.mem_req_valid && mem_if.mem_ready;

    always @(posedge clk) begin
        tog_q <= ~tog_q;
        pv    <= {pv[1:0], acc_s && !mem_if.mem_req_wr};
        pd[0] <= mem_flag[mem_if.mem_addr[15:1]] ? mem_arr[mem_if.mem_addr[15:1]] : init_word(mem_if.mem_addr);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        if (pv[2]) rsp_total <= rsp_total + 1;
        if (acc_s && mem_if.mem_req_wr) begin
            mem_arr[mem_if.mem_addr[15:1]]  <= mem_if.mem_wdata;
            mem_flag[mem_if.mem_addr[15:1]] <= 1'b1;
            wr_addr_hist[wr_total[5:0]]     <= mem_if.mem_addr;
            wr_data_hist[wr_total[5:0]]     <= mem_if.mem_wdata;
            wr_total <= wr_total + 1;
        end
        if (acc_s && !mem_if.mem_req_wr) begin
            rd_hist[rd_total[5:0]] <= mem_if.mem_addr;
            rd_total <= rd_total + 1;
        end
    end

    // ---------------- reference model ----------------
    bit [15:0] ref_mem [32768];
    bit        ref_v   [32];
    bit [6:0]  ref_tag [32];

    task automatic ref_step(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                            output int es, output int er, output int ew, output logic [15:0] erd);
        int  idx;
        bit  hit;
        idx = int'(addr[8:4]);
        if (wr) begin
            es = 1; er = 0; ew = 1; erd = 16'h0000;
            ref_mem[addr[15:1]] = wd;
        end else begin
            hit = ref_v[idx] && (ref_tag[idx] == addr[15:9]);
            es  = hit ? 0 : MISS_STALL;
            er  = hit ? 0 : 8;
            ew  = 0;
            erd = ref_mem[addr[15:1]];
            ref_v[idx]   = 1'b1;
            ref_tag[idx] = addr[15:9];
        end
    endtask

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         output int ns, output logic [15:0] rd, output int rd0, output int wr0);
        @(negedge clk);
        rd0 = rd_total;
        wr0 = wr_total;
        cpu_if.req_valid = 1'b1;
        cpu_if.req_wr    = wr;
        cpu_if.req_addr  = addr;
        cpu_if.req_wdata = wd;
        ns = 0;
        #1;
        while (cpu_if.stall && ns < 200) begin
            ns++;
            @(negedge clk);
            #1;
        end
        if (cpu_if.stall) chk("op_timeout", 32'(cpu_if.stall), 32'd0);
        rd = cpu_if.rdata;
        @(posedge clk);
        #1;
        cpu_if.req_valid = 1'b0;
    endtask

    task automatic cmp_obs(input string nm, input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                           input int ns, input logic [15:0] rd, input int rd0, input int wr0,
                           input int es, input int er, input int ew, input logic [15:0] erd);
        logic [15:0] base;
        base = {addr[15:4], 4'h0};
        chk({nm, "_stall"}, 32'(ns), 32'(es));
        chk({nm, "_reads"}, 32'(rd_total - rd0), 32'(er));
        chk({nm, "_writes"}, 32'(wr_total - wr0), 32'(ew));
        if (!wr) chk({nm, "_rdata"}, 32'(rd), 32'(erd));
        if (er == 8 && (rd_total - rd0) == 8)
            for (int i = 0; i < 8; i++)
                chk({nm, "_rdaddr"}, 32'(rd_hist[6'(rd0 + i)]), 32'(base + 16'(2 * i)));
        if (ew == 1 && (wr_total - wr0) == 1) begin
            chk({nm, "_waddr"}, 32'(wr_addr_hist[6'(wr0)]), 32'({addr[15:1], 1'b0}));
            chk({nm, "_wdata"}, 32'(wr_data_hist[6'(wr0)]), 32'(wd));
        end
    endtask

    task automatic run_ref(input string nm, input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        int ns, rd0, wr0, es, er, ew;
        logic [15:0] rd, erd;
        ref_step(wr, addr, wd, es, er, ew, erd);
        do_op(wr, addr, wd, ns, rd, rd0, wr0);
        cmp_obs(nm, wr, addr, wd, ns, rd, rd0, wr0, es, er, ew, erd);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        int          es;
        int          er;
        int          ew;
        logic [15:0] erd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, rd0, wr0, n, r0, es, er, ew;
        logic [15:0] rd, erd, a;
        logic w;

        for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(16'(i * 2));
        for (int i = 0; i < 32; i++) ref_v[i] = 1'b0;

        vecs[0] = '{1'b0, 16'h0040, 16'h0000, MISS_STALL, 8, 0, 16'h1274};
        vecs[1] = '{1'b0, 16'h004E, 16'h0000, 0,          0, 0, 16'h127A};
        vecs[2] = '{1'b0, 16'h0840, 16'h0000, MISS_STALL, 8, 0, 16'h1A74};
        vecs[3] = '{1'b0, 16'h0040, 16'h0000, MISS_STALL, 8, 0, 16'h1274};
        vecs[4] = '{1'b1, 16'h0042, 16'hBEEF, 1,          0, 1, 16'h0000};
        vecs[5] = '{1'b0, 16'h0042, 16'h0000, 0,          0, 0, 16'hBEEF};
        vecs[6] = '{1'b1, 16'h1000, 16'h5555, 1,          0, 1, 16'h0000};
        vecs[7] = '{1'b0, 16'h1000, 16'h0000, MISS_STALL, 8, 0, 16'h5555};
        vecs[8] = '{1'b0, 16'h0043, 16'h0000, 0,          0, 0, 16'hBEEF};

        cpu_if.req_valid = 1'b0;
        cpu_if.req_wr    = 1'b0;
        cpu_if.req_addr  = 16'h0000;
        cpu_if.req_wdata = 16'h0000;

        // Reset state
        #12;
        chk("rst_stall", 32'(cpu_if.stall), 32'd0);
        chk("rst_memreq", 32'(mem_if.mem_req_valid), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            ref_step(vecs[i].wr, vecs[i].addr, vecs[i].wd, es, er, ew, erd);
            do_op(vecs[i].wr, vecs[i].addr, vecs[i].wd, ns, rd, rd0, wr0);
            cmp_obs($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd, ns, rd, rd0, wr0,
                    vecs[i].es, vecs[i].er, vecs[i].ew, vecs[i].erd);
        end

        // Store held off by mem_ready low for five cycles
        ref_step(1'b1, 16'h0046, 16'h7777, es, er, ew, erd);
        @(negedge clk);
        ready_force = 1'b0;
        wr0 = wr_total;
        cpu_if.req_valid = 1'b1;
        cpu_if.req_wr    = 1'b1;
        cpu_if.req_addr  = 16'h0046;
        cpu_if.req_wdata = 16'h7777;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (cpu_if.stall) n++;
            @(negedge clk);
        end
        chk("wlow_stall_cycles", 32'(n), 32'd5);
        chk("wlow_no_early_write", 32'(wr_total - wr0), 32'd0);
        ready_force = 1'b1;
        #1;
        chk("wlow_accept_stall", 32'(cpu_if.stall), 32'd0);
        @(posedge clk);
        #1;
        cpu_if.req_valid = 1'b0;
        chk("wlow_writes", 32'(wr_total - wr0), 32'd1);
        chk("wlow_waddr", 32'(wr_addr_hist[6'(wr0)]), 32'h0046);
        chk("wlow_wdata", 32'(wr_data_hist[6'(wr0)]), 32'h7777);
        run_ref("wlow_reload", 1'b0, 16'h0046, 16'h0000);

        // Reset in the middle of a fill
        @(negedge clk);
        r0 = rsp_total;
        cpu_if.req_valid = 1'b1;
        cpu_if.req_wr    = 1'b0;
        cpu_if.req_addr  = 16'h0280;
        n = 0;
        while ((rsp_total - r0) < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if ((rsp_total - r0) < 3) chk("midfill_timeout", 32'(rsp_total - r0), 32'd3);
        rst_n = 1'b0;
        cpu_if.req_valid = 1'b0;
        #1;
        chk("midfill_rst_stall", 32'(cpu_if.stall), 32'd0);
        chk("midfill_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("midfill_rst_memreq", 32'(mem_if.mem_req_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 32; i++) ref_v[i] = 1'b0;
        run_ref("midfill_reload", 1'b0, 16'h0280, 16'h0000);
        run_ref("midfill_oldline", 1'b0, 16'h0046, 16'h0000);

        // Fill with mem_ready toggling every cycle
        tog_en = 1'b1;
        ref_step(1'b0, 16'h0C80, 16'h0000, es, er, ew, erd);
        do_op(1'b0, 16'h0C80, 16'h0000, ns, rd, rd0, wr0);
        tog_en = 1'b0;
        chk("tog_reads", 32'(rd_total - rd0), 32'd8);
        for (int i = 0; i < 8; i++) chk("tog_rdaddr", 32'(rd_hist[6'(rd0 + i)]), 32'(16'h0C80 + 16'(2 * i)));
        chk("tog_rdata", 32'(rd), 32'(init_word(16'h0C80)));
        for (int i = 0; i < 8; i++) run_ref("tog_line", 1'b0, 16'h0C80 + 16'(2 * i), 16'h0000);

        // Random traffic against the reference model
        for (int k = 0; k < 80; k++) begin
            a = {5'($urandom_range(0, 2)), 2'b00, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            w = ($urandom_range(0, 3) == 0);
            run_ref("rand", w, a, 16'($urandom));
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 Parameters: ADDR_W=16, byte-address width; DATA_W=16, word width; LINE_WORDS=8, words per line (power of 2); NUM_LINES=32, lines (power of 2); ADDR_W SHALL exceed index+offset bits.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid  in  1  CPU access request; addr/wr/wdata held stable while stall=1.
REQ-005 req_wr  in  1  1=store, 0=load.
REQ-006 req_addr  in  ADDR_W  byte address; bit 0 ignored (word aligned).
REQ-007 req_wdata  in  DATA_W  store data.
REQ-008 rdata  out  DATA_W  load data, valid when req_valid & ~req_wr & ~stall.
REQ-009 stall  out  1  CPU must hold the request and freeze its pipeline.
REQ-010 mem_req_valid  out  1  memory request.
REQ-011 mem_req_wr  out  1  memory request is a write.
REQ-012 mem_addr  out  ADDR_W  memory byte address.
REQ-013 mem_wdata  out  DATA_W  memory write data.
REQ-014 mem_ready  in  1  memory accepts request this cycle (valid & ready = transfer).
REQ-015 mem_rvalid  in  1  one read word returned, in request order.
REQ-016 mem_rdata  in  DATA_W  returned word.

Function
REQ-017 Address split: offset=addr[log2(LINE_WORDS):1], index=next log2(NUM_LINES) bits, tag=remaining upper bits.
REQ-018 Hit = valid[index] & tag match; load hit: stall=0, rdata from array same cycle (zero-latency).
REQ-019 Write-through, no write-allocate: store SHALL always issue one memory write; a store hit also updates the array word on the transfer cycle; a store miss leaves the array unchanged.
REQ-020 FSM states IDLE, FILL, WRITE; IDLE->FILL on load miss; IDLE->WRITE on any store; FILL->IDLE after LINE_WORDS responses; WRITE->IDLE on mem_ready cycle.
REQ-021 stall=1 in IDLE on load miss or store, in FILL always, in WRITE until the mem_ready cycle (stall=0 that cycle).
REQ-022 FILL: request counter issues read addresses {tag,index,word 0..LINE_WORDS-1, 0} in order, advancing on each valid&ready; mem_req_valid drops after the last accepted request.
REQ-023 FILL: response counter writes each mem_rvalid word into array word 0..LINE_WORDS-1; requests and responses may overlap.
REQ-024 Tag written and valid set only on the last response; the request is then a hit on the following cycle (IDLE).
REQ-025 During FILL, valid[index] SHALL be cleared on the first response so a partially filled line never hits.
REQ-026 mem_rvalid outside FILL SHALL be ignored; mem_ready with mem_req_valid=0 has no effect.
REQ-027 Miss penalty with mem_ready=1 and read latency L: stall for LINE_WORDS+L+1 cycles minimum.

Reset
REQ-028 rst_n low: state=IDLE, all valid bits=0, counters=0, mem_req_valid=0, stall=0 when req_valid=0; data/tag arrays not reset.
REQ-029 Reset mid-FILL or mid-WRITE aborts; the line under fill is invalid afterwards; late mem_rvalid after reset ignored.

Structure
REQ-030 Shared package cache_pkg: FSM state enum, default parameter constants, index/offset/tag width functions.
REQ-031 One sub-module cache_data_array: NUM_LINES x LINE_WORDS x DATA_W, one async read port, one sync write port.
REQ-032 Tag and valid storage, counters and FSM reside in dm_cache.

Verification (LINE_WORDS=8, NUM_LINES=32, memory read latency 3, mem_ready=1 unless stated)
REQ-033 Cold load 0x0040 -> stall 12 cycles, 8 reads at 0x0040..0x004E, then rdata=mem[0x0040], stall=0; load 0x004E next -> hit, zero stall.
REQ-034 Load 0x0040 then load 0x0840 (same index, other tag) -> second misses and refills; reload 0x0040 misses again.
REQ-035 Store 0xBEEF to 0x0042 after fill -> one memory write 0x0042/0xBEEF, load 0x0042 hits returning 0xBEEF; store to uncached 0x1000 -> memory write, load 0x1000 misses.
REQ-036 Store with mem_ready low 5 cycles -> stall held 5 cycles, single write transfer, stall=0 on accept cycle.
REQ-037 rst_n pulsed low after 3 fill responses -> stall=0, state IDLE, reload same address misses full line.
REQ-038 mem_ready toggling every cycle during FILL -> exactly 8 reads, in order, line contents correct.
